integral_pio_sequencer: RTL and testbench

INTEGRAL_PIO_SEQUENCER -- requirements
Module: integral_pio_sequencer

---
 rtl/integral_pio_sequencer_pkg.sv | 28 ++
 rtl/integral_pio_regs.sv | 58 +++++
 rtl/integral_pio_sequencer.sv | 148 ++++++++++++++
 tb/tb_integral_pio_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_pio_sequencer_pkg.sv
// Shared types and register-map constants for the PIO engine sequencer.
package integral_pio_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_STAT  = 2'd2;
    localparam logic [1:0] ADDR_PARAM = 2'd3;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_CLR_ERR  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_OVERRUN = 2;
    localparam int unsigned STAT_TIMEOUT = 3;
    localparam int unsigned STAT_RUN_LSB = 16;

    localparam int unsigned RUN_CNT_W = 16;

endpackage

// File: rtl/integral_pio_regs.sv
// Avalon register file: PARAM and DATA storage, CONTROL decode and registered read mux.
module integral_pio_regs
    import integral_pio_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              capture,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] status,
    output logic [DATA_W-1:0] param,
    output logic              ctrl_write,
    output logic [2:0]        ctrl
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] param_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA:  rd_mux = data_q;
            ADDR_CTRL:  rd_mux = '0;
            ADDR_STAT:  rd_mux = status;
            ADDR_PARAM: rd_mux = param_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            param_q    <= '0;
            readdata_q <= '0;
        end else begin
            readdata_q <= rd_mux;
            if (capture) begin
                data_q <= result;
            end
            if (write && (address == ADDR_PARAM)) begin
                param_q <= writedata;
            end
        end
    end

    assign readdata   = readdata_q;
    assign param      = param_q;
    assign ctrl_write = write && (address == ADDR_CTRL);
    assign ctrl       = writedata[2:0];

endmodule

// File: rtl/integral_pio_sequencer.sv
// Sequencer that starts an external engine from an Avalon CONTROL write, waits for its
// completion pulse with a timeout, and captures the result.
module integral_pio_sequencer
    import integral_pio_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_param,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_result
);

    localparam int unsigned   TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      eng_param_q, eng_param_d;
    logic [RUN_CNT_W-1:0]   run_count_q, run_count_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;

    logic                   busy;
    logic                   capture;
    logic                   ctrl_write;
    logic [2:0]             ctrl;
    logic                   start_req;
    logic                   clr_done_req;
    logic                   clr_err_req;
    logic [DATA_W-1:0]      param_q;
    logic [DATA_W-1:0]      status;

    integral_pio_regs #(
        .DATA_W (DATA_W)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .capture    (capture),
        .result     (eng_result),
        .status     (status),
        .param      (param_q),
        .ctrl_write (ctrl_write),
        .ctrl       (ctrl)
    );

    assign start_req    = ctrl_write && ctrl[CTRL_START];
    assign clr_done_req = ctrl_write && ctrl[CTRL_CLR_DONE];
    assign clr_err_req  = ctrl_write && ctrl[CTRL_CLR_ERR];
    assign busy         = (state_q == StStart) || (state_q == StRun);

    always_comb begin
        status                                = '0;
        status[STAT_BUSY]                     = busy;
        status[STAT_DONE]                     = done_q;
        status[STAT_OVERRUN]                  = overrun_q;
        status[STAT_TIMEOUT]                  = timeout_q;
        status[STAT_RUN_LSB +: RUN_CNT_W]     = run_count_q;
    end

    always_comb begin
        state_d     = state_q;
        eng_param_d = eng_param_q;
        run_count_d = run_count_q;
        to_cnt_d    = to_cnt_q;
        done_d      = done_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        capture     = 1'b0;

        // Clear first so that a simultaneous overrun or timeout still sets its flag.
        if (clr_err_req) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (start_req && busy) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_req) begin
                    done_d      = 1'b0;
                    eng_param_d = param_q;
                    state_d     = StStart;
                end else if ((state_q == StDone) && clr_done_req) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StRun;
            end
            StRun: begin
                if (eng_done) begin
                    capture     = 1'b1;
                    done_d      = 1'b1;
                    run_count_d = run_count_q + 1'b1;
                    state_d     = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == TO_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            eng_param_q <= '0;
            run_count_q <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_param_q <= eng_param_d;
            run_count_q <= run_count_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign eng_start = (state_q == StStart);
    assign eng_param = eng_param_q;

endmodule

// File: tb/tb_integral_pio_sequencer.sv
// Self-checking bench for integral_pio_sequencer: scoreboarded register reads and start pulses.
module tb_integral_pio_sequencer;
    import integral_pio_sequencer_pkg::*;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 8;

    localparam logic [31:0] WR_START    = 32'h0000_0001;
    localparam logic [31:0] WR_CLR_DONE = 32'h0000_0002;
    localparam logic [31:0] WR_CLR_ERR  = 32'h0000_0004;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              eng_start;
    logic [DATA_W-1:0] eng_param;
    logic              eng_done;
    logic [DATA_W-1:0] eng_result;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] start_q[$];
    logic [31:0] got;
    logic [31:0] exp_v;
    logic [15:0] runs;
    logic [31:0] mon_exp;
    logic        start_prev = 1'b0;

    always #5 clk = ~clk;

    integral_pio_sequencer #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .eng_start  (eng_start),
        .eng_param  (eng_param),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    // Start-pulse scoreboard: every pulse must match a queued expected eng_param.
    initial forever begin
        @(negedge clk);
        if (eng_start === 1'b1) begin
            checks++;
            if (start_prev === 1'b1) begin
                $display("FAIL eng_start_width: got high for 2+ cycles, want 1 cycle");
            end else if (start_q.size() == 0) begin
                $display("FAIL eng_start_unexpected: got pulse (eng_param %h), want none",
                         eng_param);
            end else begin
                mon_exp = start_q.pop_front();
                if (eng_param !== mon_exp) begin
                    $display("FAIL eng_param_at_start: got %h want %h", eng_param, mon_exp);
                end else begin
                    passed++;
                end
            end
        end
        start_prev = eng_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic pulse_done(input logic [31:0] r);
        eng_done   = 1'b1;
        eng_result = r;
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = '0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (eng_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (eng_start !== 1'b1) $display("FAIL wait_eng_start: got no pulse in 20 cycles");
        else passed++;
    endtask

    task automatic launch(input logic [31:0] p, input logic [31:0] ctrl_word);
        av_write(ADDR_PARAM, p);
        start_q.push_back(p);
        av_write(ADDR_CTRL, ctrl_word);
        wait_start();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({eng_start, eng_param, readdata} !== '0) begin
            $display("FAIL reset_outputs: got start %b param %h rd %h, want all 0",
                     eng_start, eng_param, readdata);
        end else passed++;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'h0);
            av_read(2'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL reset_reg%0d: got %h want %h", a, got, exp_v);
            else passed++;
        end
        runs = 16'd0;
    endtask

    task automatic test_basic_run();
        launch(32'h10, WR_START);
        repeat (3) tick();
        pulse_done(32'h1234_5678);
        runs = runs + 16'd1;
        pulse_done(32'h0BAD_0BAD);  // ignored in DONE
        exp_q.push_back({runs, 16'h0002});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL basic_status: got %h want %h", got, exp_v);
        else passed++;
        exp_q.push_back(32'h1234_5678);
        av_read(ADDR_DATA, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL basic_data: got %h want %h", got, exp_v);
        else passed++;
        exp_q.push_back(32'h0);
        av_read(ADDR_CTRL, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL ctrl_reads_zero: got %h want %h", got, exp_v);
        else passed++;
        av_write(ADDR_CTRL, WR_CLR_DONE);
        exp_q.push_back({runs, 16'h0000});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL clr_done_status: got %h want %h", got, exp_v);
        else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] ctrl_seq[3];
        logic [15:0] stat_seq[3];
        launch(32'h20, WR_START);
        ctrl_seq = '{WR_START, WR_CLR_ERR, WR_START | WR_CLR_ERR};
        stat_seq = '{16'h0005, 16'h0001, 16'h0005};
        for (int i = 0; i < 3; i++) begin
            av_write(ADDR_CTRL, ctrl_seq[i]);
            exp_q.push_back({runs, stat_seq[i]});
            av_read(ADDR_STAT, got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL overrun_step%0d: got %h want %h", i, got, exp_v);
            else passed++;
        end
        pulse_done(32'hCAFE_0001);
        runs = runs + 16'd1;
        exp_q.push_back({runs, 16'h0006});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL overrun_done: got %h want %h", got, exp_v);
        else passed++;
        av_write(ADDR_CTRL, WR_CLR_ERR);
        exp_q.push_back({runs, 16'h0002});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL overrun_clr: got %h want %h", got, exp_v);
        else passed++;
        av_write(ADDR_CTRL, WR_CLR_DONE);
    endtask

    task automatic test_ignored();
        pulse_done(32'hDEAD_BEEF);  // eng_done in IDLE
        av_write(ADDR_DATA, 32'hFFFF_FFFF);
        av_write(ADDR_STAT, 32'hFFFF_FFFF);
        exp_q.push_back(32'hCAFE_0001);
        av_read(ADDR_DATA, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL ignored_data: got %h want %h", got, exp_v);
        else passed++;
        exp_q.push_back({runs, 16'h0000});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL ignored_status: got %h want %h", got, exp_v);
        else passed++;
    endtask

    task automatic test_timeout();
        launch(32'h30, WR_START);
        address = ADDR_STAT;
        // readdata at the k-th negedge reflects cycle k-1 after the START cycle.
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k <= 9) ? {runs, 16'h0001} : {runs, 16'h0008});
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (readdata !== exp_v) begin
                $display("FAIL timeout_cycle%0d: got %h want %h", k, readdata, exp_v);
            end else passed++;
        end
        exp_q.push_back(32'hCAFE_0001);
        av_read(ADDR_DATA, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL timeout_data: got %h want %h", got, exp_v);
        else passed++;
        av_write(ADDR_CTRL, WR_CLR_ERR);
        exp_q.push_back({runs, 16'h0000});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL timeout_clr: got %h want %h", got, exp_v);
        else passed++;
    endtask

    task automatic test_wrap();
        // Stands in for 65535 completed runs.
        force dut.run_count_q = 16'hFFFF;
        tick();
        release dut.run_count_q;
        runs = 16'hFFFF;
        exp_q.push_back({runs, 16'h0000});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL wrap_preset: got %h want %h", got, exp_v);
        else passed++;
        launch(32'h40, WR_START);
        tick();
        pulse_done(32'h0000_0777);
        runs = runs + 16'd1;
        exp_q.push_back({runs, 16'h0002});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL wrap_status: got %h want %h", got, exp_v);
        else passed++;
    endtask

    task automatic test_reset_in_run();
        launch(32'h50, WR_START);
        tick();
        reset      = 1'b1;
        eng_done   = 1'b1;
        eng_result = 32'hBAD0_BAD0;
        tick();
        reset      = 1'b0;
        eng_done   = 1'b0;
        eng_result = '0;
        runs       = 16'd0;
        checks++;
        if ({eng_start, eng_param, readdata} !== '0) begin
            $display("FAIL run_reset_outputs: got start %b param %h rd %h, want all 0",
                     eng_start, eng_param, readdata);
        end else passed++;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'h0);
            av_read(2'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) $display("FAIL run_reset_reg%0d: got %h want %h", a, got, exp_v);
            else passed++;
        end
        launch(32'h77, WR_START);
        repeat (2) tick();
        pulse_done(32'h0000_600D);
        runs = runs + 16'd1;
        exp_q.push_back(32'h0000_600D);
        av_read(ADDR_DATA, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL after_reset_data: got %h want %h", got, exp_v);
        else passed++;
    endtask

    task automatic test_param_hold();
        launch(32'h44, WR_START | WR_CLR_DONE);  // from DONE; acts as START alone
        tick();
        av_write(ADDR_PARAM, 32'h55);
        checks++;
        if (eng_param !== 32'h44) $display("FAIL param_hold: got %h want %h", eng_param, 32'h44);
        else passed++;
        exp_q.push_back(32'h55);
        av_read(ADDR_PARAM, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL param_readback: got %h want %h", got, exp_v);
        else passed++;
        pulse_done(32'h0000_4444);
        runs = runs + 16'd1;
        start_q.push_back(32'h55);
        av_write(ADDR_CTRL, WR_START);
        wait_start();
        tick();
        pulse_done(32'h0000_5555);
        runs = runs + 16'd1;
        exp_q.push_back({runs, 16'h0002});
        av_read(ADDR_STAT, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) $display("FAIL param_final_status: got %h want %h", got, exp_v);
        else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        write      = 1'b0;
        writedata  = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        test_reset();
        test_basic_run();
        test_overrun();
        test_ignored();
        test_timeout();
        test_wrap();
        test_reset_in_run();
        test_param_hold();
        repeat (2) tick();
        checks++;
        if (start_q.size() != 0) begin
            $display("FAIL missing_start: got %0d pulses outstanding, want 0", start_q.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
